// File: rtl/mem_access_ctrl_if.sv
// Bundle of the pipeline request/response handshake and the data-memory strobes.
// The slave modport is the controller. The master modport is the pipeline side
// lumped together with the memory, which is how a bench drives it.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 20
);
    logic              i_req_valid;
    logic              o_req_ready;
    logic [1:0]        i_op;
    logic              i_size32;
    logic [ADDR_W-1:0] i_addr;
    logic [31:0]       i_wdata;
    logic              o_rsp_valid;
    logic [31:0]       o_rsp_data;
    logic              o_stack_err;
    logic [ADDR_W-1:0] o_sp;
    logic              o_mem_read;
    logic              o_mem_write;
    logic              o_mem_en32;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic [31:0]       i_mem_rdata;

    modport slave (
        input  i_req_valid, i_op, i_size32, i_addr, i_wdata, i_mem_rdata,
        output o_req_ready, o_rsp_valid, o_rsp_data, o_stack_err, o_sp,
               o_mem_read, o_mem_write, o_mem_en32, o_mem_addr, o_mem_wdata
    );

    modport master (
        output i_req_valid, i_op, i_size32, i_addr, i_wdata, i_mem_rdata,
        input  o_req_ready, o_rsp_valid, o_rsp_data, o_stack_err, o_sp,
               o_mem_read, o_mem_write, o_mem_en32, o_mem_addr, o_mem_wdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences data-memory load/store/push/pop accesses for the
// pipeline memory stage and owns the descending stack pointer.
// Optional feature macro: STACK_BOUND_CHK_EN. When it is defined, stack ops
// that would leave [STACK_LIMIT, SP_INIT] are rejected with o_stack_err.
module mem_access_ctrl #(
    parameter int                ADDR_W      = 20,
    parameter logic [ADDR_W-1:0] SP_INIT     = ADDR_W'(20'h003FF),
    parameter logic [ADDR_W-1:0] STACK_LIMIT = ADDR_W'(20'h00200)
) (
    input  logic               clk,
    input  logic               i_rst_n,
    mem_access_ctrl_if.slave   bus
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_PUSH  = 2'b10;
    localparam logic [1:0] OP_POP   = 2'b11;

`ifdef STACK_BOUND_CHK_EN
    localparam logic CHK_EN = 1'b1;
`else
    localparam logic CHK_EN = 1'b0;
`endif

    localparam logic [ADDR_W:0] ONE_X = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] TWO_X = (ADDR_W+1)'(2);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sp_q;
    logic [ADDR_W-1:0] addr_p0;
    logic [31:0]       wdata_p0;
    logic              en32_p0;
    logic              rd_p0;
    logic              vld_p1;
    logic              err_p1;
    logic [31:0]       rsp_data_p1;

    logic              accept;
    logic              is_read_op;
    logic              raw_illegal;
    logic              illegal;
    logic [ADDR_W-1:0] acc_addr;
    logic [ADDR_W-1:0] sp_next;
    logic [ADDR_W:0]   sp_ext;
    logic [ADDR_W:0]   lim_ext;
    logic [ADDR_W:0]   init_ext;

    assign accept     = bus.i_req_valid && (state_q == IDLE);
    assign is_read_op = (bus.i_op == OP_LOAD) || (bus.i_op == OP_POP);
    assign sp_ext     = {1'b0, sp_q};
    assign lim_ext    = {1'b0, STACK_LIMIT};
    assign init_ext   = {1'b0, SP_INIT};
    assign illegal    = CHK_EN && raw_illegal;

    // Access address and post-op SP, both derived from the pre-update SP.
    always_comb begin
        acc_addr = bus.i_addr;
        sp_next  = sp_q;
        case (bus.i_op)
            OP_PUSH: begin
                acc_addr = bus.i_size32 ? sp_q - ADDR_W'(1) : sp_q;
                sp_next  = bus.i_size32 ? sp_q - ADDR_W'(2) : sp_q - ADDR_W'(1);
            end
            OP_POP: begin
                acc_addr = sp_q + ADDR_W'(1);
                sp_next  = bus.i_size32 ? sp_q + ADDR_W'(2) : sp_q + ADDR_W'(1);
            end
            default: begin
                acc_addr = bus.i_addr;
                sp_next  = sp_q;
            end
        endcase
    end

    // Stack bound test done one bit wider so it cannot be fooled by wrap-around.
    always_comb begin
        raw_illegal = 1'b0;
        case (bus.i_op)
            OP_PUSH: raw_illegal = bus.i_size32 ? (sp_ext < lim_ext + ONE_X)
                                                : (sp_ext < lim_ext);
            OP_POP:  raw_illegal = bus.i_size32 ? (sp_ext + TWO_X > init_ext)
                                                : (sp_ext + ONE_X > init_ext);
            default: raw_illegal = 1'b0;
        endcase
    end

    // FSM state register; reset forces IDLE so strobes drop asynchronously.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // FSM next state: rejected stack ops never leave IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !illegal) state_d = ACCESS;
            ACCESS:  state_d = rd_p0 ? CAPTURE : IDLE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: request capture and SP update at the accept edge.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sp_q     <= SP_INIT;
            addr_p0  <= '0;
            wdata_p0 <= '0;
            en32_p0  <= 1'b0;
            rd_p0    <= 1'b0;
        end else if (accept && !illegal) begin
            sp_q     <= sp_next;
            addr_p0  <= acc_addr;
            wdata_p0 <= bus.i_wdata;
            en32_p0  <= bus.i_size32;
            rd_p0    <= is_read_op;
        end
    end

    // Stage p1: one-cycle response pulse, error flag and read-data capture.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p1      <= 1'b0;
            err_p1      <= 1'b0;
            rsp_data_p1 <= '0;
        end else begin
            vld_p1 <= 1'b0;
            err_p1 <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept && illegal) begin
                        vld_p1 <= 1'b1;
                        err_p1 <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (!rd_p0) vld_p1 <= 1'b1;
                end
                CAPTURE: begin
                    vld_p1      <= 1'b1;
                    rsp_data_p1 <= en32_p0 ? bus.i_mem_rdata
                                           : {16'h0000, bus.i_mem_rdata[15:0]};
                end
                default: begin
                    vld_p1 <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_req_ready = (state_q == IDLE);
    assign bus.o_mem_read  = (state_q == ACCESS) &&  rd_p0;
    assign bus.o_mem_write = (state_q == ACCESS) && !rd_p0;
    assign bus.o_mem_en32  = (state_q == ACCESS) &&  en32_p0;
    assign bus.o_mem_addr  = addr_p0;
    assign bus.o_mem_wdata = wdata_p0;
    assign bus.o_rsp_valid = vld_p1;
    assign bus.o_stack_err = err_p1;
    assign bus.o_rsp_data  = rsp_data_p1;
    assign bus.o_sp        = sp_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a small word-addressed memory model
// (low word at A, high word at A+1, read data registered on the read strobe).
module tb_mem_access_ctrl;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_PUSH  = 2'b10;
    localparam logic [1:0] OP_POP   = 2'b11;

    logic clk;
    logic rst_n;
    logic mem_clr;

    mem_access_ctrl_if #(.ADDR_W(20)) bus ();

    mem_access_ctrl #(
        .ADDR_W      (20),
        .SP_INIT     (20'h003FF),
        .STACK_LIMIT (20'h00200)
    ) dut (
        .clk     (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [15:0] mem [0:2047];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: writes and registered reads on the strobes.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 16'h0000;
            bus.i_mem_rdata <= 32'h0;
        end else begin
            if (bus.o_mem_write) begin
                mem[bus.o_mem_addr[10:0]] <= bus.o_mem_wdata[15:0];
                if (bus.o_mem_en32)
                    mem[11'(bus.o_mem_addr[10:0] + 11'd1)] <= bus.o_mem_wdata[31:16];
            end
            if (bus.o_mem_read)
                bus.i_mem_rdata <= {mem[11'(bus.o_mem_addr[10:0] + 11'd1)],
                                    mem[bus.o_mem_addr[10:0]]};
        end
    end

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Observations gathered by do_op.
    int          r_lat;
    logic        r_got;
    logic        r_rd;
    logic        r_wr;
    logic        r_both;
    logic        r_en32;
    logic [19:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_data;
    logic        r_err;

    task automatic do_op(input logic [1:0] op, input logic sz,
                         input logic [19:0] addr, input logic [31:0] wd);
        @(negedge clk);
        chk_val("ready", {31'd0, bus.o_req_ready}, 32'd1);
        bus.i_req_valid = 1'b1;
        bus.i_op        = op;
        bus.i_size32    = sz;
        bus.i_addr      = addr;
        bus.i_wdata     = wd;
        @(posedge clk);
        #1;
        bus.i_req_valid = 1'b0;
        r_got = 0; r_rd = 0; r_wr = 0; r_both = 0; r_en32 = 0;
        r_addr = '0; r_wdata = '0; r_data = '0; r_err = 0; r_lat = -1;
        for (int n = 0; n < 8 && !r_got; n++) begin
            @(negedge clk);
            if (bus.o_mem_read || bus.o_mem_write) begin
                r_rd    = bus.o_mem_read;
                r_wr    = bus.o_mem_write;
                r_both  = bus.o_mem_read && bus.o_mem_write;
                r_en32  = bus.o_mem_en32;
                r_addr  = bus.o_mem_addr;
                r_wdata = bus.o_mem_wdata;
            end
            if (bus.o_rsp_valid) begin
                r_got  = 1;
                r_lat  = n;
                r_data = bus.o_rsp_data;
                r_err  = bus.o_stack_err;
            end
        end
        chk_val("rsp_seen", {31'd0, r_got}, 32'd1);
    endtask

    initial begin
        rst_n           = 1'b0;
        mem_clr         = 1'b1;
        bus.i_req_valid = 1'b0;
        bus.i_op        = 2'b00;
        bus.i_size32    = 1'b0;
        bus.i_addr      = '0;
        bus.i_wdata     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        mem_clr = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);

        // Reset state
        chk_val("rst_sp",    {12'd0, bus.o_sp}, 32'h3FF);
        chk_val("rst_ready", {31'd0, bus.o_req_ready}, 32'd1);
        chk_val("rst_strb",  {29'd0, bus.o_mem_read, bus.o_mem_write, bus.o_mem_en32}, 32'd0);
        chk_val("rst_rsp",   {30'd0, bus.o_rsp_valid, bus.o_stack_err}, 32'd0);
        chk_val("rst_rdata", bus.o_rsp_data, 32'd0);
        chk_val("rst_maddr", {12'd0, bus.o_mem_addr}, 32'd0);
        chk_val("rst_mwdat", bus.o_mem_wdata, 32'd0);

        // Reset asserted while a store is in ACCESS
        @(negedge clk);
        bus.i_req_valid = 1'b1;
        bus.i_op        = OP_STORE;
        bus.i_size32    = 1'b0;
        bus.i_addr      = 20'h00020;
        bus.i_wdata     = 32'h00005555;
        @(posedge clk);
        #1;
        bus.i_req_valid = 1'b0;
        chk_val("mr_wr_hi", {31'd0, bus.o_mem_write}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_val("mr_wr_drop", {31'd0, bus.o_mem_write}, 32'd0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk_val("mr_no_rsp", {31'd0, bus.o_rsp_valid}, 32'd0);
        end
        rst_n = 1'b1;
        chk_val("mr_no_write", {16'd0, mem[11'h020]}, 32'd0);

        // STORE32 then LOAD32
        do_op(OP_STORE, 1'b1, 20'h00010, 32'hDEADBEEF);
        chk_val("st32_lat",   r_lat, 32'd1);
        chk_val("st32_strb",  {29'd0, r_rd, r_wr, r_en32}, 32'b011);
        chk_val("st32_addr",  {12'd0, r_addr}, 32'h010);
        chk_val("st32_wdata", r_wdata, 32'hDEADBEEF);
        chk_val("st32_rdata_hold", r_data, 32'd0);

        do_op(OP_LOAD, 1'b1, 20'h00010, 32'h0);
        chk_val("ld32_lat",  r_lat, 32'd2);
        chk_val("ld32_strb", {29'd0, r_rd, r_wr, r_en32}, 32'b101);
        chk_val("ld32_addr", {12'd0, r_addr}, 32'h010);
        chk_val("ld32_data", r_data, 32'hDEADBEEF);

        // LOAD16 from the high word
        do_op(OP_LOAD, 1'b0, 20'h00011, 32'h0);
        chk_val("ld16_lat",  r_lat, 32'd2);
        chk_val("ld16_en32", {31'd0, r_en32}, 32'd0);
        chk_val("ld16_data", r_data, 32'h0000DEAD);

        // PUSH32 / POP32
        do_op(OP_PUSH, 1'b1, 20'h0, 32'h12345678);
        chk_val("psh32_addr", {12'd0, r_addr}, 32'h3FE);
        chk_val("psh32_sp",   {12'd0, bus.o_sp}, 32'h3FD);
        chk_val("psh32_strb", {29'd0, r_rd, r_wr, r_en32}, 32'b011);
        chk_val("psh32_hold", bus.o_rsp_data, 32'h0000DEAD);
        chk_val("psh32_lat",  r_lat, 32'd1);

        do_op(OP_POP, 1'b1, 20'h0, 32'h0);
        chk_val("pop32_addr", {12'd0, r_addr}, 32'h3FE);
        chk_val("pop32_data", r_data, 32'h12345678);
        chk_val("pop32_sp",   {12'd0, bus.o_sp}, 32'h3FF);
        chk_val("pop32_lat",  r_lat, 32'd2);

        // PUSH16 x2, POP16 x2
        do_op(OP_PUSH, 1'b0, 20'h0, 32'h0000AAAA);
        chk_val("psh16a_addr", {12'd0, r_addr}, 32'h3FF);
        chk_val("psh16a_sp",   {12'd0, bus.o_sp}, 32'h3FE);
        do_op(OP_PUSH, 1'b0, 20'h0, 32'h0000BBBB);
        chk_val("psh16b_addr", {12'd0, r_addr}, 32'h3FE);
        chk_val("psh16b_sp",   {12'd0, bus.o_sp}, 32'h3FD);
        do_op(OP_POP, 1'b0, 20'h0, 32'h0);
        chk_val("pop16a_addr", {12'd0, r_addr}, 32'h3FE);
        chk_val("pop16a_data", r_data, 32'h0000BBBB);
        chk_val("pop16a_rw",   {31'd0, r_both}, 32'd0);
        do_op(OP_POP, 1'b0, 20'h0, 32'h0);
        chk_val("pop16b_addr", {12'd0, r_addr}, 32'h3FF);
        chk_val("pop16b_data", r_data, 32'h0000AAAA);
        chk_val("pop16b_sp",   {12'd0, bus.o_sp}, 32'h3FF);

        // POP16 on an empty stack
        do_op(OP_POP, 1'b0, 20'h0, 32'h0);
`ifdef STACK_BOUND_CHK_EN
        chk_val("empty_lat",  r_lat, 32'd0);
        chk_val("empty_err",  {31'd0, r_err}, 32'd1);
        chk_val("empty_rd",   {31'd0, r_rd}, 32'd0);
        chk_val("empty_sp",   {12'd0, bus.o_sp}, 32'h3FF);
        chk_val("empty_data", r_data, 32'h0000AAAA);
`else
        chk_val("wrap_lat",  r_lat, 32'd2);
        chk_val("wrap_err",  {31'd0, r_err}, 32'd0);
        chk_val("wrap_rd",   {31'd0, r_rd}, 32'd1);
        chk_val("wrap_addr", {12'd0, r_addr}, 32'h400);
        chk_val("wrap_sp",   {12'd0, bus.o_sp}, 32'h400);
        chk_val("wrap_data", r_data, 32'h0);
`endif

        @(negedge clk);
        chk_val("end_pulse_low", {31'd0, bus.o_rsp_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
